mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer for the 16-bit data memory. It shares the single data memory port between two requesters: port 0, the MEM stage, and port 1, the debug/loader path. It serialises their accesses and drives MemRead, MemWrite, ALUresult and WriteData to data_memory. Read data from data_result is returned to the winning requester with a one-cycle valid pulse.

## Interface
- RD_WAIT, 0: extra cycles MemRead/address are held after issue before data_result is captured (0–7).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request; hold high with we/addr/wdata stable until gnt of that port is seen.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  16  byte address.
- wdata0 / wdata1  in  16  write data.
- gnt0 / gnt1  out  1  one-cycle pulse during the issue cycle of that port's access.
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata valid for that port.
- rdata  out  16  captured read data (shared by both ports), held until next capture.
- busy  out  1  high whenever state is not IDLE.
- MemRead  out  1  to data_memory.
- MemWrite  out  1  to data_memory.
- ALUresult  out  16  address to data_memory.
- WriteData  out  16  write data to data_memory.
- data_result  in  16  read data from data_memory.

## Operation
- Reset values: all outputs 0, state IDLE, last-grant register = port 1, wait counter 0. data_memory contents untouched (its own reset is not driven here).
- All outputs registered.
- FSM states: IDLE, ISSUE, RWAIT, CAPTURE.
- IDLE: if any req is high at the clock edge, select a winner. Latch its we/addr/wdata and id, then go to ISSUE. No req: stay.
- ISSUE: drive ALUresult = latched addr. gnt<id> = 1.
  - Write: MemWrite = 1, WriteData = latched wdata. Next state IDLE.
  - Read: MemRead = 1. Next state RWAIT if RD_WAIT > 0, else CAPTURE.
- RWAIT: MemRead and ALUresult held. Counter counts 1..RD_WAIT, then CAPTURE.
- CAPTURE: rdata <= data_result, sampled at the edge leaving the last MemRead cycle. rvalid<id> = 1 for this cycle, MemRead = 0. Next state IDLE.
- Outside ISSUE/RWAIT: MemRead = MemWrite = 0, ALUresult = 0, WriteData = 0.
- Arbitration when only one req is high: that port wins. Simultaneous requests: see Configuration.
- Only the winner's request is latched. The loser keeps req high and is considered again at the next IDLE.
- A requester must drop req the cycle after its gnt, or keep it high to queue another access. A req still high in IDLE is a new request.
- Reset mid-operation: state returns to IDLE at the next edge and the in-flight access is dropped. No further gnt/rvalid is issued for it. A write whose ISSUE cycle coincides with reset may or may not commit; the requester must re-issue.

## Timing
- Request sampled at edge ending cycle T; gnt and memory strobe in cycle T+1.
- Write: memory updated at edge ending T+1. Arbiter back in IDLE at T+2, so minimum 2 cycles per write.
- Read: rvalid at T+2+RD_WAIT. Back in IDLE at T+3+RD_WAIT.
- Back-to-back requests from the same port are granted at best every 2 cycles (write) or 3+RD_WAIT cycles (read).
- busy is high from T+1 through the last non-IDLE cycle.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous req0 and req1, the port not granted last wins. The last-grant register updates at every grant. After reset, port 0 wins the first tie.
- Not defined: fixed priority, port 0 always wins ties. The last-grant register is not implemented.

## Test plan
- Single write then read, RD_WAIT=0: port 0 writes 0xBEEF to 0x0010, then reads 0x0010.
  - gnt0 pulses once per access; MemWrite high exactly 1 cycle.
  - rvalid0 two cycles after the read request is sampled, with rdata = 0xBEEF.
- Read latency, RD_WAIT=3: port 1 reads 0xF0F0 (preloaded 0x1234).
  - MemRead high for 4 cycles; rvalid1 at T+5; rdata = 0x1234; busy high for 5 cycles.
- Tie with MEM_ARB_ROUND_ROBIN_EN defined: both ports hold write requests for 4 accesses.
  - Grants alternate 0,1,0,1.
- Tie without the macro: the same stimulus gives grants 0,0,0,0 while req0 stays high.
  - Port 1 is granted on the first IDLE after req0 drops.
- Reset during RWAIT, RD_WAIT=2: assert reset for 1 cycle during the wait.
  - No rvalid; all outputs 0 the next cycle.
  - A subsequent read completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and access sequencer for the 16-bit data memory.
// Port 0 is the MEM stage and port 1 is the debug/loader path. Accesses are
// serialised onto the single data_memory port. Read data comes back on the
// shared rdata bus, marked by a one-cycle rvalid pulse for the winning port.
//
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//   defined     - simultaneous requests alternate between the ports, starting
//                 with port 0 after reset
//   not defined - fixed priority, port 0 always wins a tie
//
// Parameter:
//   RD_WAIT (0..7) - extra cycles MemRead and the address are held after issue
//                    before data_result is captured
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req0/req1, we0/we1         request and write-enable per port
//   addr0/addr1, wdata0/wdata1 address and write data per port
//   gnt0/gnt1                  one-cycle pulse in the issue cycle of the access
//   rvalid0/rvalid1            one-cycle pulse when rdata holds that port's data
//   rdata                      last captured read data, shared by both ports
//   busy                       high whenever the sequencer is not idle
//   MemRead, MemWrite          strobes to data_memory
//   ALUresult, WriteData       address and write data to data_memory
//   data_result                read data from data_memory
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; a winner is chosen and latched
// ISSUE   | strobe driven to memory, grant pulse to the winner
// RWAIT   | read held on the memory port for RD_WAIT extra cycles
// CAPTURE | read data registered, rvalid pulse to the winner

module mem_arbiter #(
  parameter int RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [15:0] ALUresult,
  output logic [15:0] WriteData,
  input  logic [15:0] data_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RWAIT, S_CAPTURE} state_e;

  localparam logic [2:0] RdWaitC = 3'(RD_WAIT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        id_q, id_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [15:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [15:0] alu_q, alu_d;
  logic [15:0] wdata_out_q, wdata_out_d;

  logic        win_id;
  logic        win_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // On a tie the port that was not granted last wins.
  always_comb win_id = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (state_q == S_IDLE && (req0 || req1)) begin
      last_q <= win_id;
    end
  end
`else
  always_comb win_id = ~req0;
`endif

  assign win_we = win_id ? we1 : we0;

  // Outputs are registered, so each branch computes the values the outputs
  // must show during the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    id_d        = id_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata_d     = rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_d       = 16'h0000;
    wdata_out_d = 16'h0000;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_ISSUE;
          id_d    = win_id;
          we_d    = win_we;
          gnt0_d  = ~win_id;
          gnt1_d  = win_id;
          alu_d   = win_id ? addr1 : addr0;
          if (win_we) begin
            mem_write_d = 1'b1;
            wdata_out_d = win_id ? wdata1 : wdata0;
          end else begin
            mem_read_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else if (RdWaitC != 3'd0) begin
          state_d    = S_RWAIT;
          cnt_d      = 3'd1;
          mem_read_d = 1'b1;
          alu_d      = alu_q;
        end else begin
          // Last MemRead cycle ends here: capture on this edge.
          state_d   = S_CAPTURE;
          rdata_d   = data_result;
          rvalid0_d = ~id_q;
          rvalid1_d = id_q;
        end
      end
      S_RWAIT: begin
        if (cnt_q == RdWaitC) begin
          state_d   = S_CAPTURE;
          cnt_d     = 3'd0;
          rdata_d   = data_result;
          rvalid0_d = ~id_q;
          rvalid1_d = id_q;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          mem_read_d = 1'b1;
          alu_d      = alu_q;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      id_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata_q     <= 16'h0000;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_q       <= 16'h0000;
      wdata_out_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      id_q        <= id_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_q       <= alu_d;
      wdata_out_q <= wdata_out_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign MemRead   = mem_read_q;
  assign MemWrite  = mem_write_q;
  assign ALUresult = alu_q;
  assign WriteData = wdata_out_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter.
// Three instances share one clock: RD_WAIT = 0, 3 and 2. Each has a small
// 256-word memory model indexed by the low address byte.
// Tie expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.

module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [3];
  logic        req0     [3];
  logic        req1     [3];
  logic        we0      [3];
  logic        we1      [3];
  logic [15:0] addr0    [3];
  logic [15:0] addr1    [3];
  logic [15:0] wdata0   [3];
  logic [15:0] wdata1   [3];
  logic        gnt0     [3];
  logic        gnt1     [3];
  logic        rvalid0  [3];
  logic        rvalid1  [3];
  logic [15:0] rdata    [3];
  logic        busy     [3];
  logic        MemRead  [3];
  logic        MemWrite [3];
  logic [15:0] ALUresult[3];
  logic [15:0] WriteData[3];
  logic [15:0] data_result[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [15:0] mem [256];

    mem_arbiter #(.RD_WAIT(g == 0 ? 0 : (g == 1 ? 3 : 2))) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .req0       (req0[g]),
      .req1       (req1[g]),
      .we0        (we0[g]),
      .we1        (we1[g]),
      .addr0      (addr0[g]),
      .addr1      (addr1[g]),
      .wdata0     (wdata0[g]),
      .wdata1     (wdata1[g]),
      .gnt0       (gnt0[g]),
      .gnt1       (gnt1[g]),
      .rvalid0    (rvalid0[g]),
      .rvalid1    (rvalid1[g]),
      .rdata      (rdata[g]),
      .busy       (busy[g]),
      .MemRead    (MemRead[g]),
      .MemWrite   (MemWrite[g]),
      .ALUresult  (ALUresult[g]),
      .WriteData  (WriteData[g]),
      .data_result(data_result[g])
    );

    assign data_result[g] = mem[ALUresult[g][7:0]];

    always @(posedge clk) begin
      if (MemWrite[g]) mem[ALUresult[g][7:0]] <= WriteData[g];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input int g, input string pfx);
    chk1 ($sformatf("%s_gnt0_%0d", pfx, g), gnt0[g], 1'b0);
    chk1 ($sformatf("%s_gnt1_%0d", pfx, g), gnt1[g], 1'b0);
    chk1 ($sformatf("%s_rvalid0_%0d", pfx, g), rvalid0[g], 1'b0);
    chk1 ($sformatf("%s_rvalid1_%0d", pfx, g), rvalid1[g], 1'b0);
    chk1 ($sformatf("%s_busy_%0d", pfx, g), busy[g], 1'b0);
    chk1 ($sformatf("%s_memread_%0d", pfx, g), MemRead[g], 1'b0);
    chk1 ($sformatf("%s_memwrite_%0d", pfx, g), MemWrite[g], 1'b0);
    chk16($sformatf("%s_alu_%0d", pfx, g), ALUresult[g], 16'h0000);
    chk16($sformatf("%s_wd_%0d", pfx, g), WriteData[g], 16'h0000);
    chk16($sformatf("%s_rdata_%0d", pfx, g), rdata[g], 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ids;
    int         rd_cycles;

    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; req0[g] = 1'b0; req1[g] = 1'b0; we0[g] = 1'b0; we1[g] = 1'b0;
      addr0[g] = 16'h0; addr1[g] = 16'h0; wdata0[g] = 16'h0; wdata1[g] = 16'h0;
    end
    tick();
    tick();
    for (int g = 0; g < 3; g++) chk_all_zero(g, "reset");
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;

    // Port 0 write then read, RD_WAIT=0
    req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 16'h0010; wdata0[0] = 16'hBEEF;
    tick();
    chk1 ("wr_gnt0", gnt0[0], 1'b1);
    chk1 ("wr_gnt1", gnt1[0], 1'b0);
    chk1 ("wr_memwrite", MemWrite[0], 1'b1);
    chk1 ("wr_memread", MemRead[0], 1'b0);
    chk16("wr_alu", ALUresult[0], 16'h0010);
    chk16("wr_wd", WriteData[0], 16'hBEEF);
    chk1 ("wr_busy", busy[0], 1'b1);
    req0[0] = 1'b0;
    tick();
    chk1 ("wr_gnt0_end", gnt0[0], 1'b0);
    chk1 ("wr_memwrite_end", MemWrite[0], 1'b0);
    chk1 ("wr_busy_end", busy[0], 1'b0);
    req0[0] = 1'b1; we0[0] = 1'b0;
    tick();
    chk1 ("rd0_gnt0", gnt0[0], 1'b1);
    chk1 ("rd0_memread", MemRead[0], 1'b1);
    chk16("rd0_alu", ALUresult[0], 16'h0010);
    chk1 ("rd0_rvalid_early", rvalid0[0], 1'b0);
    req0[0] = 1'b0;
    tick();
    chk1 ("rd0_rvalid0", rvalid0[0], 1'b1);
    chk1 ("rd0_rvalid1", rvalid1[0], 1'b0);
    chk16("rd0_rdata", rdata[0], 16'hBEEF);
    chk1 ("rd0_memread_off", MemRead[0], 1'b0);
    chk1 ("rd0_gnt0_off", gnt0[0], 1'b0);
    chk1 ("rd0_busy_capture", busy[0], 1'b1);
    tick();
    chk1 ("rd0_rvalid_end", rvalid0[0], 1'b0);
    chk1 ("rd0_busy_end", busy[0], 1'b0);
    chk16("rd0_rdata_held", rdata[0], 16'hBEEF);

    // Port 1 preload then read with RD_WAIT=3
    req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 16'hF0F0; wdata1[1] = 16'h1234;
    tick();
    chk1 ("pl_gnt1", gnt1[1], 1'b1);
    chk1 ("pl_memwrite", MemWrite[1], 1'b1);
    req1[1] = 1'b0;
    tick();
    req1[1] = 1'b1; we1[1] = 1'b0;
    rd_cycles = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) req1[1] = 1'b0;
      if (MemRead[1] === 1'b1) rd_cycles++;
      chk1 ($sformatf("rd3_gnt1_c%0d", k), gnt1[1], k == 1);
      chk1 ($sformatf("rd3_memread_c%0d", k), MemRead[1], k <= 4);
      chk1 ($sformatf("rd3_rvalid1_c%0d", k), rvalid1[1], k == 5);
      chk1 ($sformatf("rd3_rvalid0_c%0d", k), rvalid0[1], 1'b0);
      chk1 ($sformatf("rd3_busy_c%0d", k), busy[1], k <= 5);
      if (k <= 4) chk16($sformatf("rd3_alu_c%0d", k), ALUresult[1], 16'hF0F0);
      if (k == 5) chk16("rd3_rdata", rdata[1], 16'h1234);
    end
    chk16("rd3_memread_len", 16'(rd_cycles), 16'd4);

    // Tie between two write requesters, instance 0 freshly reset
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk1("tie_busy_reset", busy[0], 1'b0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 16'h0020; wdata0[0] = 16'hA0A0;
    req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 16'h0030; wdata1[0] = 16'hB1B1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1 ($sformatf("tie_gnt1_%0d", i), gnt1[0], exp_ids[i]);
      chk1 ($sformatf("tie_gnt0_%0d", i), gnt0[0], ~exp_ids[i]);
      chk16($sformatf("tie_wd_%0d", i), WriteData[0], exp_ids[i] ? 16'hB1B1 : 16'hA0A0);
      chk16($sformatf("tie_alu_%0d", i), ALUresult[0], exp_ids[i] ? 16'h0030 : 16'h0020);
      if (i == 3) req0[0] = 1'b0;
      tick();
      chk1 ($sformatf("tie_idle_busy_%0d", i), busy[0], 1'b0);
      chk1 ($sformatf("tie_idle_gnt_%0d", i), gnt0[0] | gnt1[0], 1'b0);
    end
    tick();
    chk1 ("tie_last_gnt1", gnt1[0], 1'b1);
    chk1 ("tie_last_gnt0", gnt0[0], 1'b0);
    chk16("tie_last_wd", WriteData[0], 16'hB1B1);
    req1[0] = 1'b0;
    tick();
    chk1 ("tie_done_busy", busy[0], 1'b0);

    // Reset during RWAIT, RD_WAIT=2
    req0[2] = 1'b1; we0[2] = 1'b1; addr0[2] = 16'h0040; wdata0[2] = 16'h5A5A;
    tick();
    chk1("rw_pl_gnt0", gnt0[2], 1'b1);
    req0[2] = 1'b0;
    tick();
    req0[2] = 1'b1; we0[2] = 1'b0;
    tick();
    chk1("rw_gnt0", gnt0[2], 1'b1);
    chk1("rw_memread_issue", MemRead[2], 1'b1);
    req0[2] = 1'b0;
    tick();
    chk1 ("rw_memread_wait", MemRead[2], 1'b1);
    chk16("rw_alu_wait", ALUresult[2], 16'h0040);
    chk1 ("rw_rvalid_wait", rvalid0[2], 1'b0);
    rst[2] = 1'b1;
    tick();
    chk_all_zero(2, "rw_after_reset");
    rst[2] = 1'b0;
    tick();
    chk1("rw_no_rvalid", rvalid0[2], 1'b0);
    chk1("rw_idle_busy", busy[2], 1'b0);
    req0[2] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) req0[2] = 1'b0;
      chk1($sformatf("rw2_gnt0_c%0d", k), gnt0[2], k == 1);
      chk1($sformatf("rw2_memread_c%0d", k), MemRead[2], k <= 3);
      chk1($sformatf("rw2_rvalid0_c%0d", k), rvalid0[2], k == 4);
      chk1($sformatf("rw2_busy_c%0d", k), busy[2], k <= 4);
      if (k == 4) chk16("rw2_rdata", rdata[2], 16'h5A5A);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
